md_bus_merge: RTL
=================

# md_bus_merge

Parametrised registered bus resolver for the board top level. It merges up to `SRC` tri-state/open-drain drivers onto one `WIDTH`-bit net, supporting wired-OR or wired-AND resolution, and resolves undriven bits with either a keeper or a fixed pull value. It also detects and counts driver contention. It generalises the per-net merge used for VD/VA/ZD/ZA and the strobe lines, so that every shared net on the board comes from one block with contention diagnostics.

## Interface
Parameters:
- `WIDTH`, 16, bus width in bits.
- `SRC`, 4, number of drivers (≥2).
- `WIRED_AND`, 0: 0 = wired-OR of driven values; 1 = wired-AND (open-drain, active-low strobes).
- `KEEP`, 1: 1 = undriven bit holds its last `bus_o` value; 0 = undriven bit takes `PULL_VAL`.
- `PULL_VAL`, all-ones, undriven value and reset value of `bus_o`.
- `CONT_WINDOW`, 4, consecutive conflicting cycles (1..255) required to flag contention.

Ports:
- `MCLK2`  in  1  system clock, all state on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `src_o`  in  SRC*WIDTH  driver values; source k occupies bits [k*WIDTH +: WIDTH].
- `src_d`  in  SRC*WIDTH  per-bit release, packed like `src_o`. 1 = not driving; 0 = driving.
- `clr`  in  1  clears sticky contention state.
- `bus_o`  out  WIDTH  resolved bus, registered.
- `bus_float`  out  WIDTH  registered; 1 = no source drove that bit last cycle.
- `contention`  out  1  sticky flag.
- `cont_src`  out  SRC  sources involved in the flagged contention.
- `cont_count`  out  16  saturating count of contention events.

## Operation
Per-bit resolution, using the inputs sampled in cycle t:
- No driver: the next value is `bus_o[i]` if `KEEP`, otherwise `PULL_VAL[i]`.
- One or more drivers: the next value is the OR of the driven values (`WIRED_AND=0`) or the AND of the driven values (`WIRED_AND=1`).
- `bus_float[i]` is set when no driver is active on that bit.

Conflict:
- A bit conflicts when at least 2 sources drive it with differing values.
- `conf_any` is the OR of conflicts across all bits.
- `conf_mask[k]` is set when source k drives any conflicting bit.
- Under `WIRED_AND`, a driven 0 against a driven 1 is still a conflict. Diagnostics are mode-independent.

Contention FSM, states IDLE, SUSPECT, FLAGGED, with a run counter `run` (8 bits):
- IDLE:
  - `conf_any` → SUSPECT, `run`=1, accumulate mask := `conf_mask`.
  - If `CONT_WINDOW`=1, go directly to FLAGGED.
- SUSPECT:
  - `conf_any`=0 → IDLE, `run`=0, accumulated mask discarded.
  - `conf_any`=1 → `run`+1, accumulate mask |= `conf_mask`.
  - When `run`+1 = `CONT_WINDOW` → FLAGGED.
- Entry to FLAGGED:
  - `contention`=1.
  - `cont_src` := accumulated mask including the current cycle.
  - `cont_count` += 1, saturating at 16'hFFFF.
- FLAGGED: sticky regardless of `conf_any`. Further conflicts OR into `cont_src` but do not increment `cont_count`.
- `clr`:
  - Has priority in every state: next state IDLE, `run`=0, `contention`=0, `cont_src`=0.
  - `cont_count` is not cleared.
  - A conflict present in the same cycle as `clr` is ignored; detection restarts the following cycle.
- `cont_count` is cleared only by `RESET`.

## Timing
- Reset values, asynchronous on `RESET`=0:
  - `bus_o`=`PULL_VAL`, `bus_float`=all-ones.
  - `contention`=0, `cont_src`=0, `cont_count`=0.
  - state IDLE, `run`=0.
- Data latency: inputs at edge t appear on `bus_o`/`bus_float` after edge t+1. No combinational path from inputs to outputs.
- Contention latency: conflict sampled at edges t..t+W-1 (W=`CONT_WINDOW`) → `contention`=1 and `cont_count` updated after edge t+W-1.
- A single conflict-free cycle within the window resets detection.
- Reset deasserted mid-operation: the first edge after deassertion resolves normally from the reset `bus_o`. The keeper holds `PULL_VAL` until a driver appears.
- `clr` is level-sensitive, so holding it high keeps the FSM in IDLE.

## Structure
- Package `md_bus_pkg`:
  - FSM state enum (`BM_IDLE`, `BM_SUSPECT`, `BM_FLAGGED`).
  - Mode constants `BM_WIRED_OR`/`BM_WIRED_AND`.
  - Width constant for `cont_count` (16).
- Sub-module `md_bus_contend`: holds the FSM, run counter, mask accumulator and saturating counter. Its inputs are `conf_any`, `conf_mask` and `clr`.
- The top level holds the per-bit resolution loop and the output registers.

## Test plan
- WIDTH=16, SRC=4, wired-OR, KEEP=1: source 0 drives 16'h1234 for 1 cycle, then all release → `bus_o`=16'h1234 one cycle later and held; `bus_float`=16'hFFFF.
- KEEP=0, PULL_VAL=16'hFFFF, WIRED_AND=1: sources 1 and 2 drive bit 0 to 0 and 0 → `bus_o`=16'hFFFE, no conflict. Then source 2 drives bit 0 to 1 → `bus_o`[0]=0 and `conf_any` set.
- CONT_WINDOW=4: sources 0 and 3 conflict on bit 5 for 3 cycles, then 1 clean cycle, then 4 cycles → `contention` rises only after the 4th cycle of the second run; `cont_src`=4'b1001, `cont_count`=1.
- FLAGGED with continued conflict: assert `clr` for 1 cycle → `contention`=0 and `cont_src`=0 the next cycle. The flag re-asserts 4 cycles later and `cont_count`=2.
- Saturation: force `cont_count`=16'hFFFE via repeated flag/clr cycles → it reaches 16'hFFFF and stays there on further events.
- Assert `RESET` low mid-SUSPECT with a driven bus → all outputs return asynchronously to reset values; after release `bus_o`=`PULL_VAL` until the first driver appears.

Source files
------------

// File: rtl/md_bus_pkg.sv
// rtl/md_bus_pkg.sv - shared types and constants for the board bus resolver
package md_bus_pkg;

  typedef enum logic [1:0] {
    BM_IDLE    = 2'd0,
    BM_SUSPECT = 2'd1,
    BM_FLAGGED = 2'd2
  } bm_state_e;

  localparam int BM_WIRED_OR  = 0;
  localparam int BM_WIRED_AND = 1;

  localparam int BM_CNT_W = 16;

  function automatic logic [BM_CNT_W-1:0] bm_sat_inc(input logic [BM_CNT_W-1:0] v);
    return (v == {BM_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/md_bus_contend.sv
// rtl/md_bus_contend.sv - contention detector: conflict-run FSM, source mask and event counter
module md_bus_contend
  import md_bus_pkg::*;
#(
  parameter int SRC         = 4,
  parameter int CONT_WINDOW = 4
) (
  input  logic                MCLK2,
  input  logic                RESET,
  input  logic                conf_any,
  input  logic [SRC-1:0]      conf_mask,
  input  logic                clr,
  output logic                contention,
  output logic [SRC-1:0]      cont_src,
  output logic [BM_CNT_W-1:0] cont_count
);

  localparam logic [7:0] WIN = 8'(CONT_WINDOW);

  bm_state_e             state_q;
  logic [7:0]            run_q;
  logic [SRC-1:0]        acc_q;
  logic                  flag_q;
  logic [SRC-1:0]        src_q;
  logic [BM_CNT_W-1:0]   cnt_q;

  always_ff @(posedge MCLK2 or negedge RESET) begin
    if (!RESET) begin
      state_q <= BM_IDLE;
      run_q   <= '0;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      // cnt_q survives clr; only RESET clears the event count
      state_q <= BM_IDLE;
      run_q   <= '0;
      acc_q   <= '0;
      flag_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      case (state_q)
        BM_IDLE: begin
          if (conf_any) begin
            run_q <= 8'd1;
            if (WIN == 8'd1) begin
              state_q <= BM_FLAGGED;
              flag_q  <= 1'b1;
              src_q   <= conf_mask;
              cnt_q   <= bm_sat_inc(cnt_q);
            end else begin
              state_q <= BM_SUSPECT;
              acc_q   <= conf_mask;
            end
          end
        end
        BM_SUSPECT: begin
          if (!conf_any) begin
            state_q <= BM_IDLE;
            run_q   <= '0;
            acc_q   <= '0;
          end else begin
            run_q <= run_q + 8'd1;
            acc_q <= acc_q | conf_mask;
            if (run_q + 8'd1 == WIN) begin
              state_q <= BM_FLAGGED;
              flag_q  <= 1'b1;
              src_q   <= acc_q | conf_mask;
              cnt_q   <= bm_sat_inc(cnt_q);
            end
          end
        end
        BM_FLAGGED: src_q <= src_q | conf_mask;
        default:    state_q <= BM_IDLE;
      endcase
    end
  end

  assign contention = flag_q;
  assign cont_src   = src_q;
  assign cont_count = cnt_q;

endmodule

// File: rtl/md_bus_merge.sv
// rtl/md_bus_merge.sv - registered multi-driver bus resolver with contention diagnostics
module md_bus_merge
  import md_bus_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               SRC         = 4,
  parameter int               WIRED_AND   = 0,
  parameter int               KEEP        = 1,
  parameter logic [WIDTH-1:0] PULL_VAL    = '1,
  parameter int               CONT_WINDOW = 4
) (
  input  logic                 MCLK2,
  input  logic                 RESET,
  input  logic [SRC*WIDTH-1:0] src_o,
  input  logic [SRC*WIDTH-1:0] src_d,
  input  logic                 clr,
  output logic [WIDTH-1:0]     bus_o,
  output logic [WIDTH-1:0]     bus_float,
  output logic                 contention,
  output logic [SRC-1:0]       cont_src,
  output logic [BM_CNT_W-1:0]  cont_count
);

  logic [WIDTH-1:0] bus_q, bus_d;
  logic [WIDTH-1:0] float_q, float_d;
  logic [WIDTH-1:0] conf_bits;
  logic [SRC-1:0]   conf_mask;
  logic             conf_any;
  logic             any_v, or_v, and_v;

  always_comb begin
    bus_d     = bus_q;
    float_d   = '1;
    conf_bits = '0;
    conf_mask = '0;
    any_v     = 1'b0;
    or_v      = 1'b0;
    and_v     = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      any_v = 1'b0;
      or_v  = 1'b0;
      and_v = 1'b1;
      for (int k = 0; k < SRC; k++) begin
        if (!src_d[k*WIDTH+i]) begin
          any_v = 1'b1;
          or_v  = or_v | src_o[k*WIDTH+i];
          and_v = and_v & src_o[k*WIDTH+i];
        end
      end
      // a driven 1 and a driven 0 on the same bit is a conflict in either wiring mode
      float_d[i]   = ~any_v;
      conf_bits[i] = any_v & or_v & ~and_v;
      if (any_v)
        bus_d[i] = (WIRED_AND == BM_WIRED_AND) ? and_v : or_v;
      else
        bus_d[i] = (KEEP != 0) ? bus_q[i] : PULL_VAL[i];
    end
    for (int k = 0; k < SRC; k++)
      conf_mask[k] = |(~src_d[k*WIDTH +: WIDTH] & conf_bits);
  end

  assign conf_any = |conf_bits;

  always_ff @(posedge MCLK2 or negedge RESET) begin
    if (!RESET) begin
      bus_q   <= PULL_VAL;
      float_q <= '1;
    end else begin
      bus_q   <= bus_d;
      float_q <= float_d;
    end
  end

  md_bus_contend #(
    .SRC         (SRC),
    .CONT_WINDOW (CONT_WINDOW)
  ) u_contend (
    .MCLK2      (MCLK2),
    .RESET      (RESET),
    .conf_any   (conf_any),
    .conf_mask  (conf_mask),
    .clr        (clr),
    .contention (contention),
    .cont_src   (cont_src),
    .cont_count (cont_count)
  );

  assign bus_o     = bus_q;
  assign bus_float = float_q;

endmodule
